// File: rtl/jt7759_fifo_data.sv
// rtl/jt7759_fifo_data.sv - jt7759 data front-end: ROM pass-through (master) or host byte FIFO (slave)
// Optional live level/overflow status: define JT7759_FIFO_STATUS_EN.
module jt7759_fifo_data #(
    parameter int DEPTH    = 4,
    parameter int AW       = 17,
    parameter int LOW_WM   = 2,
    parameter int DRQ_HOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen4,
    input  logic                     mdn,
    input  logic                     ctrl_flush,
    input  logic                     ctrl_cs,
    input  logic [AW-1:0]            ctrl_addr,
    output logic [7:0]               ctrl_din,
    output logic                     ctrl_ok,
    output logic                     rom_cs,
    output logic [AW-1:0]            rom_addr,
    input  logic [7:0]               rom_data,
    input  logic                     rom_ok,
    input  logic                     cs,
    input  logic                     wrn,
    input  logic [7:0]               din,
    output logic                     drqn,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int HW = $clog2(DRQ_HOLD + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ok_q, ok_d, drqn_q, drqn_d, pend_q, pend_d;
    logic          last_wrn_q, last_cs_q, mdn_q;

    logic flush, strobe, rd_req, pop, full, push;

    // Master mode keeps the FIFO flushed so switching back to slave starts clean.
    assign flush  = ctrl_flush || mdn || (mdn != mdn_q);
    assign strobe = cs && !wrn && last_wrn_q;
    assign rd_req = ctrl_cs && (!last_cs_q || pend_q);
    assign pop    = rd_req && (cnt_q != '0) && !flush;
    assign full   = (cnt_q == LW'(DEPTH));
    assign push   = strobe && (!full || pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ok_d     = ok_q;
        pend_d   = pend_q;
        hold_d   = hold_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (!ctrl_cs)  ok_d = 1'b0;
        else if (pop)  ok_d = 1'b1;
        // A request that found the FIFO empty stays armed until a byte arrives.
        if (!ctrl_cs || pop) pend_d = 1'b0;
        else if (rd_req)     pend_d = 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ok_d     = 1'b0;
            pend_d   = 1'b0;
        end
        if (strobe)                       hold_d = HW'(DRQ_HOLD);
        else if (cen4 && hold_q != '0)    hold_d = hold_q - HW'(1);
        drqn_d = strobe || !(hold_q == '0 && cnt_q < LW'(LOW_WM) && !ctrl_flush);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rdata_q    <= 8'd0;
            ok_q       <= 1'b0;
            pend_q     <= 1'b0;
            hold_q     <= HW'(DRQ_HOLD);
            drqn_q     <= 1'b1;
            last_wrn_q <= 1'b1;
            last_cs_q  <= 1'b0;
            mdn_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ok_q       <= ok_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            drqn_q     <= drqn_d;
            last_wrn_q <= wrn;
            last_cs_q  <= ctrl_cs;
            mdn_q      <= mdn;
        end
    end

`ifdef JT7759_FIFO_STATUS_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop = strobe && full && !pop && !flush;

    always_comb begin
        ovf_d = flush ? 1'b0 : (ovf_q || drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign level = cnt_q;
    assign ovf   = ovf_q;
`else
    assign level = '0;
    assign ovf   = 1'b0;
`endif

    assign rom_cs   = mdn ? ctrl_cs : 1'b0;
    assign rom_addr = ctrl_addr;
    assign ctrl_din = mdn ? rom_data : rdata_q;
    assign ctrl_ok  = mdn ? rom_ok : ok_q;
    assign drqn     = mdn ? 1'b1 : drqn_q;
endmodule

// File: tb/tb_jt7759_fifo_data.sv
// tb/tb_jt7759_fifo_data.sv - scoreboard bench for jt7759_fifo_data
module tb_jt7759_fifo_data;
    localparam int AW = 17;
`ifdef JT7759_FIFO_STATUS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, cen4, mdn, ctrl_flush, ctrl_cs;
    logic [AW-1:0] ctrl_addr, rom_addr;
    logic [7:0]    ctrl_din, rom_data, din;
    logic          ctrl_ok, rom_cs, rom_ok, cs, wrn, drqn, ovf;
    logic [2:0]    level;

    jt7759_fifo_data dut (
        .clk(clk), .rst_n(rst_n), .cen4(cen4), .mdn(mdn), .ctrl_flush(ctrl_flush),
        .ctrl_cs(ctrl_cs), .ctrl_addr(ctrl_addr), .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .cs(cs), .wrn(wrn), .din(din), .drqn(drqn), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t sb_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic ok_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every ctrl_ok rise is a delivered byte; match it against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ctrl_ok === 1'b1 && ok_prev === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got byte %0h expected none", ctrl_din);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", {24'd0, ctrl_din}, {24'd0, e.d});
                chk("sb_cycle", cyc, e.c);
            end
        end
        ok_prev <= ctrl_ok;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cen4 = 1'b1;
        step(1);
        cen4 = 1'b0;
    endtask

    task automatic host_wr(input logic [7:0] b);
        cs = 1'b1; wrn = 1'b0; din = b;
        step(1);
        wrn = 1'b1; cs = 1'b0;
        step(1);
    endtask

    task automatic pulse(input logic [7:0] b);
        sb_q.push_back('{b, cyc + 1});
        ctrl_cs = 1'b1;
        step(2);
        ctrl_cs = 1'b0;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cen4 = 1'b0; mdn = 1'b0; ctrl_flush = 1'b0; ctrl_cs = 1'b0;
        ctrl_addr = '0; rom_data = 8'd0; rom_ok = 1'b0; cs = 1'b0; wrn = 1'b1; din = 8'd0;
        step(2);
        chk("rst_drqn", drqn, 1);
        chk("rst_ok", ctrl_ok, 0);
        chk("rst_din", ctrl_din, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        step(1);

        tick(); tick(); tick();
        chk("idle_drqn", drqn, 0);
        chk("idle_ok", ctrl_ok, 0);

        host_wr(8'h11); host_wr(8'h22); host_wr(8'h33); host_wr(8'h44);
        chk("full_level", level, ST ? 4 : 0);
        chk("full_ovf0", ovf, 0);
        host_wr(8'h55);
        chk("drop_level", level, ST ? 4 : 0);
        chk("drop_ovf", ovf, ST ? 1 : 0);
        chk("wr_drqn", drqn, 1);
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
        chk("drain_level", level, 0);
        chk("ovf_sticky", ovf, ST ? 1 : 0);

        ctrl_cs = 1'b1;
        step(3);
        chk("empty_stall", ctrl_ok, 0);
        sb_q.push_back('{8'hA5, cyc + 2});
        cs = 1'b1; wrn = 1'b0; din = 8'hA5;
        step(1);
        wrn = 1'b1; cs = 1'b0;
        step(1);
        chk("pend_ok", ctrl_ok, 1);
        ctrl_cs = 1'b0;
        step(2);
        chk("pend_level", level, 0);
        chk("pend_ok_clr", ctrl_ok, 0);

        host_wr(8'h01);
        tick(); tick(); step(1);
        chk("drq_low_l1", drqn, 0);
        host_wr(8'h02);
        chk("drq_push_hi", drqn, 1);
        tick();
        chk("drq_tick1", drqn, 1);
        pulse(8'h01);
        tick();
        chk("drq_hold_exact", drqn, 1);
        step(1);
        chk("drq_release", drqn, 0);
        host_wr(8'h03);
        tick(); tick(); step(2);
        chk("drq_high_wm", drqn, 1);

        host_wr(8'h04);
        chk("pre_flush_level", level, ST ? 3 : 0);
        ctrl_flush = 1'b1; cs = 1'b1; wrn = 1'b0; din = 8'h66;
        step(1);
        ctrl_flush = 1'b0; wrn = 1'b1; cs = 1'b0;
        step(1);
        chk("flush_level", level, 0);
        chk("flush_ovf", ovf, 0);
        ctrl_cs = 1'b1;
        step(3);
        chk("flush_stall", ctrl_ok, 0);
        ctrl_cs = 1'b0;
        step(1);
        host_wr(8'h77);
        pulse(8'h77);

        sb_q.push_back('{8'h7E, cyc});
        mdn = 1'b1; rom_data = 8'h7E; rom_ok = 1'b1; ctrl_cs = 1'b1; ctrl_addr = 17'h1ABCD;
        #1;
        chk("m_rom_cs", rom_cs, 1);
        chk("m_rom_addr", rom_addr, 17'h1ABCD);
        chk("m_din", ctrl_din, 8'h7E);
        chk("m_ok", ctrl_ok, 1);
        chk("m_drqn", drqn, 1);
        step(1);
        host_wr(8'h99);
        chk("m_drqn_wr", drqn, 1);
        ctrl_cs = 1'b0; rom_ok = 1'b0; mdn = 1'b0;
        #1;
        chk("s_rom_cs", rom_cs, 0);
        step(2);
        chk("s_level", level, 0);
        chk("s_ok", ctrl_ok, 0);
        host_wr(8'h88);
        pulse(8'h88);

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            step(1);
        end
        chk("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jt7759_fifo_data.md
Name: jt7759_fifo_data

Overview:
- Parametrised data front-end for the jt7759 ADPCM decoder; sits between the decoder control FSM and either external ROM (master mode, mdn=1) or a host CPU pushing bytes (slave mode, mdn=0).
- Slave mode uses a DEPTH-entry byte FIFO with watermark-driven DRQn pacing, an explicit pop handshake and a flush.
- Master mode is a registered-free pass-through to ROM.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 17, ROM/control address width.
- LOW_WM, 2, DRQn may assert only while level < LOW_WM; range 1..DEPTH.
- DRQ_HOLD, 2, cen4 ticks DRQn stays high after each host write; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen4  in  1  clock enable used for DRQ hold-off timing
- mdn  in  1  1=master (ROM), 0=slave (FIFO)
- ctrl_flush  in  1  decoder request to empty the FIFO (new phrase / stop)
- ctrl_cs  in  1  decoder read request, level-held
- ctrl_addr  in  AW  decoder read address (master mode only)
- ctrl_din  out  8  byte to decoder
- ctrl_ok  out  1  ctrl_din valid
- rom_cs  out  1  ROM request
- rom_addr  out  AW  ROM address
- rom_data  in  8  ROM data
- rom_ok  in  1  ROM data valid
- cs  in  1  host chip select
- wrn  in  1  host write strobe, active low
- din  in  8  host data
- drqn  out  1  data request to host, active low
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n low, async): FIFO empty, rd/wr pointers 0, ctrl_ok=0, ctrl_din register=0, drqn=1, hold counter=DRQ_HOLD, ovf=0, last_wrn=1, last_ctrl_cs=0.
- Master (mdn=1), combinational:
  - rom_cs=ctrl_cs, rom_addr=ctrl_addr, ctrl_din=rom_data, ctrl_ok=rom_ok.
  - drqn=1.
  - FIFO held empty.
- Slave (mdn=0): rom_cs=0, rom_addr=ctrl_addr, ctrl_din/ctrl_ok come from registers.
- Push:
  - Strobe = cs && !wrn && last_wrn (wrn falling edge while selected), sampled on clk.
  - Not full: din written at wr pointer; pointer wraps modulo DEPTH; level+1.
  - Full with no pop that cycle: byte dropped, ovf set.
  - Full with simultaneous pop: push accepted.
- Pop:
  - A read transaction starts on a ctrl_cs rising edge, or is pending if ctrl_cs is high, ctrl_ok=0 and the FIFO was empty at the edge.
  - The first cycle with level>0: head copied into ctrl_din, rd pointer advances, level-1, ctrl_ok=1 on the next edge.
  - Latency: one clk from a non-empty request to ctrl_ok.
  - ctrl_ok holds until ctrl_cs falls; it clears on the first edge with ctrl_cs=0.
  - Exactly one pop per ctrl_cs high period.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Flush (ctrl_flush=1, or any mdn change detected via a registered copy):
  - Pointers and level zeroed, ctrl_ok=0, ovf cleared.
  - Same-cycle push or pop is discarded; flush wins.
- DRQn:
  - Hold counter reloads to DRQ_HOLD on each push strobe, and drqn=1 on that same edge.
  - Counter decrements on cen4 while nonzero.
  - drqn=0 when counter==0 && level<LOW_WM && !ctrl_flush, else 1.
  - Registered; changes one clk after its conditions.
- level and ovf:
  - Counter widths are $clog2(DEPTH)+1 so full (level==DEPTH) is distinct from empty.
  - Without the optional feature, both outputs read 0.

Optional Feature:
- Macro JT7759_FIFO_STATUS_EN.
- Defined: level drives live occupancy; ovf is a sticky flag cleared only by flush or reset.
- Undefined: level=0 and ovf=0 constant; the overflow register is not built; push/drop behaviour is unchanged.

Test Plan:
- Reset then mdn=0, idle for 3 cen4 ticks -> drqn=0 (level 0 < LOW_WM=2), ctrl_ok=0.
- Host writes 0x11,0x22,0x33,0x44 -> level=4, the fifth write 0x55 is dropped, ovf=1. Four ctrl_cs pulses -> ctrl_din 0x11,0x22,0x33,0x44, each with ctrl_ok one clk after the cs rise.
- ctrl_cs rises with an empty FIFO, host writes 0xA5 three clks later -> ctrl_ok=1 with ctrl_din=0xA5 one clk after the push; level returns to 0.
- Push at level 1 -> drqn goes high next clk and stays high for exactly DRQ_HOLD=2 cen4 ticks; it returns low only if level<2.
- FIFO at 3 entries, ctrl_flush coincident with a host write -> level=0, ovf=0, next ctrl_cs stalls (ctrl_ok=0).
- mdn=1, rom_data=0x7E, rom_ok=1, ctrl_cs=1 -> rom_cs=1, ctrl_din=0x7E, ctrl_ok=1 combinationally, drqn=1. Toggling mdn to 0 -> FIFO empty.
